usr_sequencer: RTL and testbench
================================

# usr_sequencer

Command-driven controller for the 4-bit universal shift register. It accepts load/shift/rotate commands over a valid/ready handshake and drives the register's `MODE` and `Data` inputs cycle by cycle. It counts the requested number of shift cycles, captures the register's serial output bit stream, and signals completion. It sits between any command master (bench, FSM, CPU-style host) and the shift register instance.

## Interface
Parameters:
- `CNT_W`, default 3: width of `cmd_count`. Supports 0..7 shifts per command.
- `CAP_W`, default 8: width of the serial capture register `cap_data`.

Ports:
- `clk` input 1: single clock, all logic on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `cmd_valid` input 1: command present.
- `cmd_ready` output 1: controller can accept a command.
- `cmd_op` input 2: 0=LOAD, 1=SHR (shift right), 2=SHL (shift left), 3=ROT (rotate right).
- `cmd_count` input CNT_W: number of shift cycles. Ignored for LOAD.
- `cmd_data` input 4: parallel value for LOAD.
- `pause` input 1: freezes an in-progress shift sequence.
- `serial_Q` input 1: serial output of the shift register.
- `Data` output 4: to the register's parallel input.
- `MODE` output 3: to the register. 0=hold, 1=shift right, 2=shift left, 3=parallel load, 4=rotate right.
- `busy` output 1: command in progress.
- `done` output 1: one-cycle completion pulse.
- `cap_data` output CAP_W: serial bits captured during the last command.

## Operation
- States: IDLE, LOAD, SHIFT, DONE. Outputs are registered.
- Reset forces the following on the first rising edge with `rst`=1, regardless of state: IDLE, `cmd_ready`=1, `busy`=0, `done`=0, `MODE`=0, `Data`=0, `cap_data`=0, counter=0.
- IDLE:
  - `cmd_ready`=1, `MODE`=0.
  - A command is accepted on the edge where `cmd_valid`&&`cmd_ready`.
  - On accept: `cap_data` clears to 0 and `busy` goes to 1.
  - LOAD goes to state LOAD.
  - SHR, SHL or ROT with `cmd_count`≠0 goes to SHIFT, with counter = `cmd_count`.
  - SHR, SHL or ROT with `cmd_count`=0 goes directly to DONE.
- LOAD: `MODE`=3 and `Data`=`cmd_data` latched at accept, for exactly one cycle, then DONE.
- SHIFT:
  - `MODE` = 1, 2 or 4 for SHR, SHL or ROT respectively.
  - Each edge in SHIFT with `pause`=0: counter decrements, and `cap_data` <= {`cap_data`[CAP_W-2:0], `serial_Q`}. The sampled bit is the one being shifted out by that edge.
  - While `pause`=1: `MODE`=0, and the counter and `cap_data` hold.
  - When the counter reaches 0 the state goes to DONE. `MODE` therefore shows a shift code for exactly `cmd_count` unpaused cycles.
- DONE: `done`=1, `busy`=0, `MODE`=0 for one cycle, then IDLE.
- `cmd_ready`=0 in every state except IDLE. Commands presented while busy are not accepted and are not lost. The master holds `cmd_valid` until it sees `cmd_ready`.
- `Data` retains the last loaded value outside LOAD.
- `cap_data` retains its value after DONE until the next accept.
- More than CAP_W shifts keep only the newest CAP_W bits.

## Timing
- Accept edge T:
  - LOAD: `MODE`=3 during T..T+1, register loads at T+1, `done` during T+1..T+2, `cmd_ready`=1 again from T+2.
  - Shift of N≥1 with no pause: `MODE` is a shift code during cycles T..T+N. The register updates on edges T+1..T+N. `done` is high during cycle T+N, and the next accept is possible at edge T+N+2.
  - Shift with N=0: `done` during T..T+1, `MODE` stays 0.
- Each cycle of `pause` in SHIFT adds exactly one cycle of latency.
- `pause` in IDLE, LOAD or DONE has no effect.
- A new command can be accepted no earlier than the cycle after DONE. Back-to-back throughput is therefore LOAD every 3 cycles, and shift-N every N+2 cycles.
- `rst` mid-SHIFT aborts immediately: `MODE`=0 the next cycle, no `done` pulse.

## Test plan
- Reset: hold `rst` 2 cycles mid-SHIFT -> next cycle IDLE, `MODE`=0, `busy`=0, `cap_data`=0, no `done`.
- LOAD 4'b0111 -> `MODE`=3 for 1 cycle, register parallel out = 0111, `done` for 1 cycle, latency 2 cycles to `cmd_ready`.
- LOAD 0111, then SHR count 4 -> `MODE`=1 for exactly 4 cycles, `cap_data`[3:0] equals the 4 bits seen on `serial_Q`, register out 0000 (zero fill), `done` once.
- LOAD 1001, then ROT count 4 with `pause` high for 2 cycles mid-sequence -> `MODE`=4 for 4 cycles total with `MODE`=0 during pause, register back to 1001, `done` 2 cycles later than unpaused.
- SHL count 0 -> immediate DONE, `MODE` never nonzero, `cap_data`=0.
- `cmd_valid` held high with a second command while busy -> not accepted until after DONE, then executes exactly once.

Source files
------------

// File: rtl/usr_sequencer.sv
// usr_sequencer
//   Command-driven controller for a 4-bit universal shift register. Accepts
//   LOAD / SHR / SHL / ROT commands over a valid/ready handshake, drives the
//   register's MODE and Data inputs, counts shift cycles, captures the serial
//   output stream and pulses done when a command completes.
//
// Ports
//   clk        : single clock, rising edge
//   rst        : synchronous active-high reset
//   cmd_valid  : command present
//   cmd_ready  : controller can accept a command (IDLE only)
//   cmd_op     : 0=LOAD 1=SHR 2=SHL 3=ROT
//   cmd_count  : shift cycles for SHR/SHL/ROT, ignored for LOAD
//   cmd_data   : parallel value for LOAD
//   pause      : freezes an in-progress shift sequence
//   serial_Q   : serial output of the shift register
//   Data       : parallel value to the register
//   MODE       : 0=hold 1=shr 2=shl 3=load 4=rotate right
//   busy       : command in progress
//   done       : one-cycle completion pulse
//   cap_data   : serial bits captured during the last command
module usr_sequencer #(
  parameter int CNT_W = 3,
  parameter int CAP_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic [3:0]       cmd_data,
  input  logic             pause,
  input  logic             serial_Q,
  output logic [3:0]       Data,
  output logic [2:0]       MODE,
  output logic             busy,
  output logic             done,
  output logic [CAP_W-1:0] cap_data
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_DONE
  } state_t;

  localparam logic [1:0] OP_LOAD = 2'd0;
  localparam logic [1:0] OP_SHR  = 2'd1;
  localparam logic [1:0] OP_SHL  = 2'd2;

  localparam logic [2:0] MODE_HOLD = 3'd0;
  localparam logic [2:0] MODE_SHR  = 3'd1;
  localparam logic [2:0] MODE_SHL  = 3'd2;
  localparam logic [2:0] MODE_LOAD = 3'd3;
  localparam logic [2:0] MODE_ROT  = 3'd4;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       mode_r, mode_nxt;
  logic [3:0]       data_nxt;
  logic [CAP_W-1:0] cap_nxt;
  logic             busy_nxt, done_nxt, ready_nxt;

  function automatic logic [2:0] shift_code(input logic [1:0] op);
    case (op)
      OP_SHR:  shift_code = MODE_SHR;
      OP_SHL:  shift_code = MODE_SHL;
      default: shift_code = MODE_ROT;
    endcase
  endfunction

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    mode_nxt  = mode_r;
    data_nxt  = Data;
    cap_nxt   = cap_data;
    busy_nxt  = busy;
    done_nxt  = 1'b0;
    ready_nxt = cmd_ready;

    case (state)
      S_IDLE: begin
        mode_nxt = MODE_HOLD;
        if (cmd_valid && cmd_ready) begin
          cap_nxt   = '0;
          ready_nxt = 1'b0;
          busy_nxt  = 1'b1;
          cnt_nxt   = cmd_count;
          if (cmd_op == OP_LOAD) begin
            state_nxt = S_LOAD;
            mode_nxt  = MODE_LOAD;
            data_nxt  = cmd_data;
          end else if (cmd_count != '0) begin
            state_nxt = S_SHIFT;
            mode_nxt  = shift_code(cmd_op);
          end else begin
            // Zero-length shift: straight to completion, MODE never leaves hold.
            state_nxt = S_DONE;
            done_nxt  = 1'b1;
            busy_nxt  = 1'b0;
          end
        end
      end

      S_LOAD: begin
        state_nxt = S_DONE;
        mode_nxt  = MODE_HOLD;
        done_nxt  = 1'b1;
        busy_nxt  = 1'b0;
      end

      S_SHIFT: begin
        if (!pause) begin
          cnt_nxt = cnt - CNT_W'(1);
          cap_nxt = {cap_data[CAP_W-2:0], serial_Q};
          if (cnt == CNT_W'(1)) begin
            state_nxt = S_DONE;
            mode_nxt  = MODE_HOLD;
            done_nxt  = 1'b1;
            busy_nxt  = 1'b0;
          end
        end
      end

      S_DONE: begin
        state_nxt = S_IDLE;
        mode_nxt  = MODE_HOLD;
        ready_nxt = 1'b1;
      end

      default: begin
        state_nxt = S_IDLE;
        mode_nxt  = MODE_HOLD;
        ready_nxt = 1'b1;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      mode_r    <= MODE_HOLD;
      Data      <= '0;
      cap_data  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cmd_ready <= 1'b1;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      mode_r    <= mode_nxt;
      Data      <= data_nxt;
      cap_data  <= cap_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      cmd_ready <= ready_nxt;
    end
  end

  // The register samples MODE on the same edge that pause freezes the counter,
  // so the shift code is masked combinationally in the paused cycle itself;
  // a registered mask would let the register shift once more than counted.
  assign MODE = (state == S_SHIFT && pause) ? MODE_HOLD : mode_r;

endmodule

// File: tb/tb_usr_sequencer.sv
module tb_usr_sequencer;
  localparam int CNT_W = 3;
  localparam int CAP_W = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [1:0]       cmd_op = '0;
  logic [CNT_W-1:0] cmd_count = '0;
  logic [3:0]       cmd_data = '0;
  logic             pause = 1'b0;
  logic             serial_Q;
  logic [3:0]       Data;
  logic [2:0]       MODE;
  logic             busy;
  logic             done;
  logic [CAP_W-1:0] cap_data;

  always #5 clk = ~clk;

  usr_sequencer #(.CNT_W(CNT_W), .CAP_W(CAP_W)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_count(cmd_count), .cmd_data(cmd_data),
    .pause(pause), .serial_Q(serial_Q), .Data(Data), .MODE(MODE),
    .busy(busy), .done(done), .cap_data(cap_data)
  );

  // environment: 4-bit universal shift register, zero fill on shifts
  logic [3:0] reg_q = 4'b0000;
  always @(posedge clk) begin
    case (MODE)
      3'd1: reg_q <= {1'b0, reg_q[3:1]};
      3'd2: reg_q <= {reg_q[2:0], 1'b0};
      3'd3: reg_q <= Data;
      3'd4: reg_q <= {reg_q[0], reg_q[3:1]};
      default: reg_q <= reg_q;
    endcase
  end
  assign serial_Q = (MODE == 3'd2) ? reg_q[3] : reg_q[0];

  typedef struct {
    logic [CAP_W-1:0] cap;
    logic [3:0]       q;
    int               mcyc;
    int               lat;
    logic [2:0]       code;
  } exp_t;

  exp_t       sb[$];
  exp_t       me;
  logic [3:0] mq = 4'b0000;
  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  int         acc_cyc = 0;
  int         mcnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [1:0] op, input int n, input logic [3:0] d,
                                 input logic [3:0] q_in);
    exp_t e;
    logic [3:0] q;
    logic b;
    q = q_in;
    e.cap = '0;
    if (op == 2'd0) begin
      e.q = d; e.mcyc = 1; e.lat = 1; e.code = 3'd3;
    end else begin
      e.code = (op == 2'd1) ? 3'd1 : (op == 2'd2) ? 3'd2 : 3'd4;
      e.mcyc = n;
      e.lat  = n;
      for (int i = 0; i < n; i++) begin
        b = (op == 2'd2) ? q[3] : q[0];
        e.cap = {e.cap[CAP_W-2:0], b};
        case (op)
          2'd1: q = {1'b0, q[3:1]};
          2'd2: q = {q[2:0], 1'b0};
          default: q = {q[0], q[3:1]};
        endcase
      end
      e.q = q;
    end
    return e;
  endfunction

  // monitor: sampled on the falling edge
  always @(negedge clk) begin
    if (!rst) begin
      if (MODE != 3'd0) begin
        mcnt++;
        if (sb.size() > 0) chk("mode_code", MODE, sb[0].code);
        else chk("mode_no_cmd", MODE, 0);
      end
      if (done) begin
        if (sb.size() == 0) begin
          chk("spurious_done", done, 0);
        end else begin
          me = sb.pop_front();
          chk("cap_data", cap_data, me.cap);
          chk("reg_q", reg_q, me.q);
          chk("mode_cycles", mcnt, me.mcyc);
          chk("done_latency", cyc - acc_cyc, me.lat);
          chk("busy_at_done", busy, 0);
          chk("ready_at_done", cmd_ready, 0);
        end
      end
      if (cmd_valid && cmd_ready) begin
        acc_cyc = cyc + 1;
        mcnt = 0;
      end
    end
  end

  // Drives a command and returns just after its accept edge with cmd_valid still high.
  task automatic send(input logic [1:0] op, input int n, input logic [3:0] d,
                      input int extra, output int acc);
    exp_t e;
    e = model(op, n, d, mq);
    e.lat += extra;
    mq = e.q;
    sb.push_back(e);
    cmd_op    = op;
    cmd_count = n[CNT_W-1:0];
    cmd_data  = d;
    cmd_valid = 1'b1;
    acc = -1;
    for (int k = 0; k < 60 && acc < 0; k++) begin
      @(negedge clk);
      if (cmd_ready) begin
        @(posedge clk);
        #2;
        acc = cyc;
      end
    end
    if (acc < 0) chk("accept_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 300 && !ok; k++) begin
      @(negedge clk);
      #1;
      if (sb.size() == 0 && cmd_ready && !done) ok = 1'b1;
    end
    if (!ok) chk("idle_timeout", 0, 1);
    @(posedge clk);
    #2;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_ready"}, cmd_ready, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_mode"}, MODE, 0);
    chk({tag, "_cap"}, cap_data, 0);
    chk({tag, "_data"}, Data, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int a1, a2, a3;
    int k;
    // reset at start
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    chk_reset_state("rst0");
    rst = 1'b0;

    // LOAD 0111
    send(2'd0, 0, 4'b0111, 0, a1);
    cmd_valid = 1'b0;
    wait_idle();

    // SHR 4: zero fill, capture 1110
    send(2'd1, 4, 4'b0000, 0, a1);
    cmd_valid = 1'b0;
    wait_idle();

    // LOAD 1001, then ROT 4 with two paused cycles
    send(2'd0, 0, 4'b1001, 0, a1);
    cmd_valid = 1'b0;
    wait_idle();
    send(2'd3, 4, 4'b0000, 2, a1);
    cmd_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2 pause = 1'b1;
    repeat (2) @(posedge clk);
    #2 pause = 1'b0;
    wait_idle();

    // SHL 0: immediate completion
    send(2'd2, 0, 4'b0000, 0, a1);
    cmd_valid = 1'b0;
    wait_idle();

    // back-to-back with cmd_valid held; pause during IDLE/LOAD is ignored
    pause = 1'b1;
    send(2'd0, 0, 4'b0101, 0, a1);
    pause = 1'b0;
    send(2'd2, 3, 4'b0000, 0, a2);
    chk("gap_after_load", a2 - a1, 3);
    send(2'd1, 2, 4'b0000, 0, a3);
    chk("gap_after_shl3", a3 - a2, 5);
    cmd_valid = 1'b0;
    wait_idle();

    // random commands, some queued while busy
    for (int i = 0; i < 10; i++) begin
      send(2'($urandom_range(0, 3)), int'($urandom_range(0, 7)), 4'($urandom), 0, a1);
      cmd_valid = 1'b0;
      k = int'($urandom_range(0, 3));
      repeat (k) begin
        @(posedge clk);
        #2;
      end
    end
    wait_idle();

    // reset in the middle of a shift
    send(2'd0, 0, 4'b1111, 0, a1);
    cmd_valid = 1'b0;
    wait_idle();
    send(2'd1, 7, 4'b0000, 0, a1);
    cmd_valid = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #2;
    end
    chk("busy_mid_shift", busy, 1);
    rst = 1'b1;
    @(posedge clk);
    #2;
    chk_reset_state("rst1a");
    @(posedge clk);
    #2;
    chk_reset_state("rst1b");
    rst = 1'b0;
    void'(sb.pop_back());
    mq = 4'b0000;
    repeat (6) begin
      @(posedge clk);
      #2;
    end
    chk("idle_after_abort", busy, 0);

    // recovery: LOAD 0011, ROT 2 -> capture 11, register 1100
    send(2'd0, 0, 4'b0011, 0, a1);
    cmd_valid = 1'b0;
    wait_idle();
    send(2'd3, 2, 4'b0000, 0, a1);
    cmd_valid = 1'b0;
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
